// File: rtl/register_file_mem_ff_mp.sv
// -----------------------------------------------------------------------------
// register_file_mem_ff_mp
//
// Flip-flop register file with one write port and NumReadPorts independent,
// registered read ports (read latency 1). Each word carries a "written" flag
// that is set by a write and cleared by reset or clear_i. clear_i only drops
// the flags; the data words keep their contents.
//
// Optional feature (macro REGFILE_WRITE_BYPASS_EN):
//   defined   -> a read and a write to the same address on the same edge
//                return the new write data with rwritten_o = 1 (write-first).
//   undefined -> read-first: such a read returns the old word and old flag,
//                and no bypass mux is built.
//
// Parameters:
//   AddrWidth     word address width, NumWords = 2**AddrWidth
//   DataWidth     signed word width
//   NumReadPorts  number of read ports (1..8)
//
// Ports:
//   clk_i       clock, all state updates on the rising edge
//   rst_i       synchronous active-high reset (clears data, flags, outputs)
//   re_i        per-port read request
//   raddr_i     per-port read address
//   rdata_o     per-port read data (signed), held while no read is issued
//   rvalid_o    per-port strobe, high the cycle after a read request
//   rwritten_o  per-port written flag of the addressed word, held like rdata_o
//   we_i        write enable
//   waddr_i     write address
//   wdata_i     write data (signed)
//   clear_i     clear all written flags, data retained
// -----------------------------------------------------------------------------
module register_file_mem_ff_mp #(
    parameter int AddrWidth    = 4,
    parameter int DataWidth    = 16,
    parameter int NumReadPorts = 2
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic        [NumReadPorts-1:0]                 re_i,
    input  logic        [NumReadPorts-1:0][AddrWidth-1:0]  raddr_i,
    output logic signed [DataWidth-1:0]                    rdata_o [NumReadPorts],
    output logic        [NumReadPorts-1:0]                 rvalid_o,
    output logic        [NumReadPorts-1:0]                 rwritten_o,
    input  logic                               we_i,
    input  logic        [AddrWidth-1:0]        waddr_i,
    input  logic signed [DataWidth-1:0]        wdata_i,
    input  logic                               clear_i
);

    localparam int NumWords = 2 ** AddrWidth;

    logic signed [DataWidth-1:0] mem [NumWords];
    logic        [NumWords-1:0]  written;

    logic signed [DataWidth-1:0] rdata_p1    [NumReadPorts];
    logic        [NumReadPorts-1:0] vld_p1;
    logic        [NumReadPorts-1:0] rwritten_p1;

    // ---- storage update ----
    // The per-word flag set by a write is assigned after the bulk clear so
    // that a simultaneous write keeps its own flag set.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int w = 0; w < NumWords; w++) begin
                mem[w] <= '0;
            end
            written <= '0;
        end else begin
            if (clear_i) begin
                written <= '0;
            end
            if (we_i) begin
                mem[waddr_i]     <= wdata_i;
                written[waddr_i] <= 1'b1;
            end
        end
    end

    // ---- stage p1: registered read ports ----
    // Data and flag are only loaded on a request so they hold otherwise;
    // the flag seen here is the pre-clear value because written is updated
    // on the same edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int p = 0; p < NumReadPorts; p++) begin
                rdata_p1[p] <= '0;
            end
            vld_p1      <= '0;
            rwritten_p1 <= '0;
        end else begin
            vld_p1 <= re_i;
            for (int p = 0; p < NumReadPorts; p++) begin
                if (re_i[p]) begin
`ifdef REGFILE_WRITE_BYPASS_EN
                    if (we_i && (waddr_i == raddr_i[p])) begin
                        rdata_p1[p]    <= wdata_i;
                        rwritten_p1[p] <= 1'b1;
                    end else begin
                        rdata_p1[p]    <= mem[raddr_i[p]];
                        rwritten_p1[p] <= written[raddr_i[p]];
                    end
`else
                    rdata_p1[p]    <= mem[raddr_i[p]];
                    rwritten_p1[p] <= written[raddr_i[p]];
`endif
                end
            end
        end
    end

    always_comb begin
        for (int p = 0; p < NumReadPorts; p++) begin
            rdata_o[p] = rdata_p1[p];
        end
    end

    assign rvalid_o   = vld_p1;
    assign rwritten_o = rwritten_p1;

endmodule

// File: tb/tb_register_file_mem_ff_mp.sv
module tb_register_file_mem_ff_mp;

    localparam int AW = 4;
    localparam int DW = 16;
    localparam int NP = 2;

`ifdef REGFILE_WRITE_BYPASS_EN
    localparam bit Bypass = 1'b1;
`else
    localparam bit Bypass = 1'b0;
`endif

    logic                      clk = 1'b0;
    logic                      rst;
    logic        [NP-1:0]          re;
    logic        [NP-1:0][AW-1:0]  raddr;
    logic signed [DW-1:0]          rdata [NP];
    logic        [NP-1:0]          rvalid;
    logic        [NP-1:0]          rwritten;
    logic                      we;
    logic        [AW-1:0]      waddr;
    logic signed [DW-1:0]      wdata;
    logic                      clear;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    register_file_mem_ff_mp #(
        .AddrWidth   (AW),
        .DataWidth   (DW),
        .NumReadPorts(NP)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .re_i      (re),
        .raddr_i   (raddr),
        .rdata_o   (rdata),
        .rvalid_o  (rvalid),
        .rwritten_o(rwritten),
        .we_i      (we),
        .waddr_i   (waddr),
        .wdata_i   (wdata),
        .clear_i   (clear)
    );

    task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, act, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] fill_val(input int i);
        return 16'h0100 + 16'(i);
    endfunction

    initial begin
        rst = 1'b1; re = '0; raddr = '0; we = 1'b0; waddr = '0; wdata = '0; clear = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_rvalid",   16'(rvalid),   16'h0);
        chk("rst_rwritten", 16'(rwritten), 16'h0);
        chk("rst_rdata0",   rdata[0],      16'h0000);
        chk("rst_rdata1",   rdata[1],      16'h0000);

        // Read addr 5 after reset
        rst = 1'b0; re = 2'b01; raddr[0] = 4'd5;
        tick();
        chk("r5_rdata0",    rdata[0],          16'h0000);
        chk("r5_rwritten0", 16'(rwritten[0]),  16'h0);
        chk("r5_rvalid0",   16'(rvalid[0]),    16'h1);
        chk("r5_rvalid1",   16'(rvalid[1]),    16'h0);

        // No request -> rvalid drops
        re = 2'b00;
        tick();
        chk("idle_rvalid0", 16'(rvalid[0]), 16'h0);

        // Write 0x7FFF to 3, read on both ports next cycle
        we = 1'b1; waddr = 4'd3; wdata = 16'sh7FFF;
        tick();
        we = 1'b0; re = 2'b11; raddr[0] = 4'd3; raddr[1] = 4'd3;
        tick();
        chk("w3_rdata0",    rdata[0],          16'h7FFF);
        chk("w3_rdata1",    rdata[1],          16'h7FFF);
        chk("w3_rwritten",  16'(rwritten),     16'h3);
        chk("w3_rvalid",    16'(rvalid),       16'h3);

        // Hold: data stays after rvalid drops
        re = 2'b00;
        tick();
        chk("hold_rvalid",  16'(rvalid),       16'h0);
        chk("hold_rdata1",  rdata[1],          16'h7FFF);

        // Same-edge read/write on addr 9
        we = 1'b1; waddr = 4'd9; wdata = 16'sh0011;
        tick();
        wdata = 16'sh8000; re = 2'b01; raddr[0] = 4'd9;
        tick();
        we = 1'b0;
        chk("rw9_rdata0",    rdata[0],         Bypass ? 16'h8000 : 16'h0011);
        chk("rw9_rwritten0", 16'(rwritten[0]), 16'h1);
        tick();
        chk("r9_rdata0",     rdata[0],         16'h8000);

        // Fill every word
        re = 2'b00;
        for (int i = 0; i < 16; i++) begin
            we = 1'b1; waddr = AW'(i); wdata = fill_val(i);
            tick();
        end

        // Clear plus write to 2, reading 2 and 7 on the same edge
        clear = 1'b1; we = 1'b1; waddr = 4'd2; wdata = 16'sh0222;
        re = 2'b11; raddr[0] = 4'd2; raddr[1] = 4'd7;
        tick();
        clear = 1'b0; we = 1'b0;
        chk("clr_rdata0",    rdata[0],         Bypass ? 16'h0222 : 16'h0102);
        chk("clr_rwritten0", 16'(rwritten[0]), 16'h1);
        chk("clr_rdata1",    rdata[1],         16'h0107);
        chk("clr_rwritten1", 16'(rwritten[1]), 16'h1);
        tick();
        chk("pc_rdata0",     rdata[0],         16'h0222);
        chk("pc_rwritten0",  16'(rwritten[0]), 16'h1);
        chk("pc_rdata1",     rdata[1],         16'h0107);
        chk("pc_rwritten1",  16'(rwritten[1]), 16'h0);

        // Write to a cleared word while reading it: flag behaviour differs by build
        we = 1'b1; waddr = 4'd7; wdata = 16'sh0777;
        raddr[0] = 4'd5; raddr[1] = 4'd7;
        tick();
        we = 1'b0;
        chk("w7_rdata1",     rdata[1],         Bypass ? 16'h0777 : 16'h0107);
        chk("w7_rwritten1",  16'(rwritten[1]), Bypass ? 16'h1 : 16'h0);
        chk("w7_rdata0",     rdata[0],         16'h0105);
        chk("w7_rwritten0",  16'(rwritten[0]), 16'h0);

        // Stream reads on port 1, reset mid-stream (write at reset edge is ignored)
        re = 2'b10;
        for (int i = 0; i < 16; i++) begin
            logic [15:0] exp_d;
            raddr[1] = AW'(i);
            rst   = (i == 8 || i == 9);
            we    = (i == 8);
            waddr = 4'd12; wdata = 16'sh5555;
            tick();
            if (i < 8) begin
                exp_d = (i == 2) ? 16'h0222 : (i == 7) ? 16'h0777 : fill_val(i);
                chk($sformatf("st%0d_rvalid1", i),   16'(rvalid[1]),   16'h1);
                chk($sformatf("st%0d_rdata1", i),    rdata[1],         exp_d);
                chk($sformatf("st%0d_rwritten1", i), 16'(rwritten[1]), (i == 2 || i == 7) ? 16'h1 : 16'h0);
            end else begin
                chk($sformatf("st%0d_rvalid1", i),   16'(rvalid[1]),   (i >= 10) ? 16'h1 : 16'h0);
                chk($sformatf("st%0d_rdata1", i),    rdata[1],         16'h0000);
                chk($sformatf("st%0d_rwritten1", i), 16'(rwritten[1]), 16'h0);
            end
            chk($sformatf("st%0d_rvalid0", i), 16'(rvalid[0]), 16'h0);
        end
        rst = 1'b0; we = 1'b0; re = 2'b00;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/register_file_mem_ff_mp.md
REGISTER_FILE_MEM_FF_MP -- requirements
Module: register_file_mem_ff_mp

Interface
REQ-001 SHALL have parameter AddrWidth, default 4, word address width; depth NumWords = 2**AddrWidth.
REQ-002 SHALL have parameter DataWidth, default 16, signed word width.
REQ-003 SHALL have parameter NumReadPorts, default 2, independent read ports (1..8).
REQ-004 SHALL have port clk_i  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port re_i  input  NumReadPorts  per-port read request.
REQ-007 SHALL have port raddr_i  input  NumReadPorts x AddrWidth  per-port read address (unsigned).
REQ-008 SHALL have port rdata_o  output  NumReadPorts x DataWidth  per-port read data (signed).
REQ-009 SHALL have port rvalid_o  output  NumReadPorts  per-port read-data-valid strobe.
REQ-010 SHALL have port rwritten_o  output  NumReadPorts  addressed word written since last reset/clear.
REQ-011 SHALL have port we_i  input  1  write enable.
REQ-012 SHALL have port waddr_i  input  AddrWidth  write address (unsigned).
REQ-013 SHALL have port wdata_i  input  DataWidth  write data (signed).
REQ-014 SHALL have port clear_i  input  1  clear all written flags; data retained.

Function
REQ-015 Storage SHALL be flip-flops, NumWords x DataWidth, plus one written flag per word; no latches, no clock gating cells.
REQ-016 we_i=1 at edge N SHALL store wdata_i into word waddr_i and set its written flag, visible to reads issued from cycle N+1.
REQ-017 re_i[p]=1 at edge N SHALL drive rdata_o[p]=mem[raddr_i[p]], rwritten_o[p]=flag, rvalid_o[p]=1 during cycle N+1 (latency 1).
REQ-018 re_i[p]=0 SHALL give rvalid_o[p]=0 next cycle; rdata_o[p], rwritten_o[p] hold last values.
REQ-019 Back-to-back reads on one port SHALL sustain one result per cycle, no bubbles.
REQ-020 Read ports SHALL be fully independent; same address on several ports SHALL return identical data.
REQ-021 Read and write to same address same edge, macro absent: read SHALL return old data and old flag.
REQ-022 clear_i=1 SHALL zero all written flags at that edge; data words unchanged.
REQ-023 clear_i and we_i same edge: all flags cleared except waddr_i flag, which SHALL be set.
REQ-024 Read with clear_i same edge SHALL return pre-clear flag (subject to REQ-029 for written address).
REQ-025 Addresses cover full 2**AddrWidth range; no out-of-range case exists.

Reset
REQ-026 rst_i=1 at an edge SHALL zero every data word, every written flag, all rdata_o, rwritten_o, rvalid_o.
REQ-027 rst_i SHALL dominate we_i, re_i, clear_i same edge; reads issued at that edge SHALL produce no rvalid_o.
REQ-028 Read issued edge before reset SHALL have its cycle N+1 result overwritten to zero by reset at edge N+1 only from N+2 onward (normal result visible in N+1).

Configuration
REQ-029 Macro REGFILE_WRITE_BYPASS_EN defined: read and write same address same edge SHALL return wdata_i with rwritten_o=1 (write-first), including when clear_i=1.
REQ-030 Macro absent: read-first per REQ-021; no bypass mux instantiated.

Verification
REQ-031 Reset, then read addr 5 on port 0 -> next cycle rdata_o[0]=0, rwritten_o[0]=0, rvalid_o[0]=1.
REQ-032 Write 0x7FFF to addr 3, next cycle read addr 3 ports 0 and 1 -> both rdata_o=0x7FFF, rwritten_o=1, one cycle later.
REQ-033 Addr 9 holds 0x0011; same edge write 0x8000 to 9 and read 9 -> 0x0011 without macro, 0x8000 (rwritten_o=1) with REGFILE_WRITE_BYPASS_EN.
REQ-034 Fill addrs 0..15, clear_i with write addr 2 same edge, read 2 and 7 -> rwritten 1 and 0, data of addr 7 unchanged.
REQ-035 Stream reads addrs 0..15 on port 1 every cycle, reset asserted mid-stream -> rvalid_o[1] continuous until reset, then 0, all data 0 afterward.
